// File: rtl/midi_uart_mk2.sv
// midi_uart_mk2 -- MIDI UART with oversampled, glitch-filtered receiver,
// RX/TX FIFOs with valid/ready handshakes and status/byte-number tracking.
// Everything runs on CLOCK_25, with a shared tick enable from a baud divider.
//
// Optional build macro: MIDI_RUNNING_STATUS_TX_EN
//   When defined, the transmitter drops a channel status byte (80-EF)
//   that repeats the last transmitted status (running status).
//
// Ports:
//   CLOCK_25      in   system clock
//   reset_reg_N   in   async active-low reset
//   midi_rxd      in   serial in (idle high, asynchronous)
//   midi_txd      out  serial out (idle high)
//   rx_data       out  head of RX FIFO
//   rx_is_status  out  head entry is a status byte
//   rx_byte_nr    out  head entry's data-byte index since its status
//   rx_valid      out  RX FIFO not empty
//   rx_ready      in   pop head when rx_valid & rx_ready
//   cur_status    out  last accepted status byte
//   sys_real      out  one-cycle pulse on a realtime byte
//   sys_real_dat  out  last realtime byte
//   framing_err   out  one-cycle pulse on bad stop bit
//   overrun       out  one-cycle pulse when a byte is dropped (RX FIFO full)
//   tx_data       in   byte to send
//   tx_valid      in   push request
//   tx_ready      out  TX FIFO not full
//   tx_busy       out  shifter active or TX FIFO non-empty
//
// RX FSM states:  IDLE | START (verify start bit at half bit) | DATA (8 bits)
//                 | STOP (sample stop bit) | WAIT (framing error, wait for high)
// TX FSM states:  IDLE | START | DATA | STOP
module midi_uart_mk2 #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16,
    parameter int RX_DEPTH   = 8,
    parameter int TX_DEPTH   = 8
) (
    input  logic       CLOCK_25,
    input  logic       reset_reg_N,
    input  logic       midi_rxd,
    output logic       midi_txd,
    output logic [7:0] rx_data,
    output logic       rx_is_status,
    output logic [7:0] rx_byte_nr,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] cur_status,
    output logic       sys_real,
    output logic [7:0] sys_real_dat,
    output logic       framing_err,
    output logic       overrun,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy
);
    localparam int DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW    = $clog2(OVERSAMPLE);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    // ---------------- tick divider ----------------
    logic [DW-1:0] div_cnt;
    logic          tick;

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt <= DW'(DIV - 1);
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt - 1'b1;
            tick    <= 1'b0;
        end
    end

    // ---------------- RX synchroniser + majority filter ----------------
    logic       rxd_meta, rxd_sync;
    logic [1:0] smp;
    logic       rx_filt;
    logic       filt_next;

    // Majority of the two previous tick samples and the current one.
    assign filt_next = (smp[0] & smp[1]) | (smp[0] & rxd_sync) | (smp[1] & rxd_sync);

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            smp      <= 2'b11;
            rx_filt  <= 1'b1;
        end else begin
            rxd_meta <= midi_rxd;
            rxd_sync <= rxd_meta;
            if (tick) begin
                smp     <= {smp[0], rxd_sync};
                rx_filt <= filt_next;
            end
        end
    end

    // ---------------- RX FSM ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    rx_state_t     rx_state;
    logic [OW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          acc_valid;
    logic [7:0]    acc_byte;

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_sh       <= '0;
            acc_valid   <= 1'b0;
            acc_byte    <= '0;
            framing_err <= 1'b0;
        end else begin
            acc_valid   <= 1'b0;
            framing_err <= 1'b0;
            if (tick) begin
                case (rx_state)
                    RX_IDLE: if (rx_filt && !filt_next) begin
                        rx_state <= RX_START;
                        rx_cnt   <= OW'(OVERSAMPLE / 2 - 1);
                    end
                    RX_START: if (rx_cnt == '0) begin
                        if (filt_next) rx_state <= RX_IDLE;
                        else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= OW'(OVERSAMPLE - 1);
                            rx_bit   <= '0;
                        end
                    end else rx_cnt <= rx_cnt - 1'b1;
                    RX_DATA: if (rx_cnt == '0) begin
                        rx_sh  <= {filt_next, rx_sh[7:1]};
                        rx_cnt <= OW'(OVERSAMPLE - 1);
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else rx_cnt <= rx_cnt - 1'b1;
                    RX_STOP: if (rx_cnt == '0) begin
                        if (filt_next) begin
                            acc_valid <= 1'b1;
                            acc_byte  <= rx_sh;
                            rx_state  <= RX_IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            rx_state    <= RX_WAIT;
                        end
                    end else rx_cnt <= rx_cnt - 1'b1;
                    RX_WAIT: if (filt_next) rx_state <= RX_IDLE;
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // ---------------- classification ----------------
    logic        is_real, is_stat, rx_push;
    logic [7:0]  byte_cnt, cnt_next;
    logic [16:0] push_word;

    assign is_real   = (acc_byte >= 8'hF8);
    assign is_stat   = acc_byte[7] && (acc_byte != 8'hF7) && !is_real;
    assign cnt_next  = (byte_cnt == 8'hFF) ? 8'hFF : byte_cnt + 8'd1;
    assign rx_push   = acc_valid && !is_real;
    assign push_word = is_stat ? {acc_byte, 1'b1, 8'h00} : {acc_byte, 1'b0, cnt_next};

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            cur_status   <= '0;
            sys_real     <= 1'b0;
            sys_real_dat <= '0;
            byte_cnt     <= '0;
        end else begin
            sys_real <= 1'b0;
            if (acc_valid) begin
                if (is_real) begin
                    sys_real_dat <= acc_byte;
                    sys_real     <= 1'b1;
                end else if (is_stat) begin
                    cur_status <= acc_byte;
                    byte_cnt   <= '0;
                end else byte_cnt <= cnt_next;
            end
        end
    end

    // ---------------- RX FIFO (first-word-fall-through) ----------------
    logic [16:0]     rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wp, rx_rp;
    logic [RX_AW:0]   rx_count;
    logic             rx_full, rx_pop, rx_wr;
    logic [16:0]      rx_head;

    assign rx_full  = (rx_count == (RX_AW+1)'(RX_DEPTH));
    assign rx_valid = (rx_count != '0);
    assign rx_pop   = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign rx_wr    = rx_push && (!rx_full || rx_pop);
    assign rx_head  = rx_mem[rx_rp];
    assign rx_data      = rx_valid ? rx_head[16:9] : 8'h00;
    assign rx_is_status = rx_valid ? rx_head[8]    : 1'b0;
    assign rx_byte_nr   = rx_valid ? rx_head[7:0]  : 8'h00;

    always_ff @(posedge CLOCK_25) begin
        if (rx_wr) rx_mem[rx_wp] <= push_word;
    end

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= rx_push && rx_full && !rx_pop;
            if (rx_wr)  rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            if (rx_wr && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (!rx_wr && rx_pop) rx_count <= rx_count - 1'b1;
        end
    end

    // ---------------- TX FIFO ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t        tx_state;
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wp, tx_rp;
    logic [TX_AW:0]   tx_count;
    logic             tx_push, tx_pop, tx_drop;
    logic [7:0]       tx_head;

    assign tx_ready = (tx_count != (TX_AW+1)'(TX_DEPTH));
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = (tx_state == TX_IDLE) && (tx_count != '0);
    assign tx_head  = tx_mem[tx_rp];
    assign tx_busy  = (tx_state != TX_IDLE) || (tx_count != '0);

    always_ff @(posedge CLOCK_25) begin
        if (tx_push) tx_mem[tx_wp] <= tx_data;
    end

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
            else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
        end
    end

`ifdef MIDI_RUNNING_STATUS_TX_EN
    logic [7:0] last_tx_status;
    logic       head_chan;

    assign head_chan = (tx_head >= 8'h80) && (tx_head <= 8'hEF);
    assign tx_drop   = head_chan && (tx_head == last_tx_status);

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) last_tx_status <= '0;
        else if (tx_pop) begin
            if (head_chan) last_tx_status <= tx_head;
            else if (tx_head >= 8'hF0 && tx_head <= 8'hF7) last_tx_status <= '0;
        end
    end
`else
    assign tx_drop = 1'b0;
`endif

    // ---------------- TX FSM ----------------
    logic [OW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            midi_txd <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_pop && !tx_drop) begin
                    tx_sh    <= tx_head;
                    midi_txd <= 1'b0;
                    tx_cnt   <= OW'(OVERSAMPLE - 1);
                    tx_state <= TX_START;
                end
                TX_START: if (tick) begin
                    if (tx_cnt == '0) begin
                        midi_txd <= tx_sh[0];
                        tx_sh    <= {1'b0, tx_sh[7:1]};
                        tx_bit   <= '0;
                        tx_cnt   <= OW'(OVERSAMPLE - 1);
                        tx_state <= TX_DATA;
                    end else tx_cnt <= tx_cnt - 1'b1;
                end
                TX_DATA: if (tick) begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= OW'(OVERSAMPLE - 1);
                        if (tx_bit == 3'd7) begin
                            midi_txd <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            midi_txd <= tx_sh[0];
                            tx_sh    <= {1'b0, tx_sh[7:1]};
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else tx_cnt <= tx_cnt - 1'b1;
                end
                TX_STOP: if (tick) begin
                    if (tx_cnt == '0) tx_state <= TX_IDLE;
                    else tx_cnt <= tx_cnt - 1'b1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_midi_uart_mk2.sv
`timescale 1ns/1ps
module tb_midi_uart_mk2;
    // Reduced clock keeps the run short; bit time stays 32 us (64 cycles of 500 ns).
    localparam int CLK_HZ = 2000000;
    localparam int BAUD   = 31250;
    localparam int OS     = 16;
    localparam int DIV    = CLK_HZ / (BAUD * OS);
    localparam int BIT    = DIV * OS;

    logic       CLOCK_25, reset_reg_N, midi_rxd, midi_txd;
    logic [7:0] rx_data, rx_byte_nr, cur_status, sys_real_dat, tx_data;
    logic       rx_is_status, rx_valid, rx_ready, sys_real, framing_err, overrun;
    logic       tx_valid, tx_ready, tx_busy;

    midi_uart_mk2 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
                    .RX_DEPTH(8), .TX_DEPTH(8)) dut (
        .CLOCK_25(CLOCK_25), .reset_reg_N(reset_reg_N),
        .midi_rxd(midi_rxd), .midi_txd(midi_txd),
        .rx_data(rx_data), .rx_is_status(rx_is_status), .rx_byte_nr(rx_byte_nr),
        .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cur_status(cur_status), .sys_real(sys_real), .sys_real_dat(sys_real_dat),
        .framing_err(framing_err), .overrun(overrun),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy)
    );

    initial begin
        CLOCK_25 = 1'b0;
        forever #250 CLOCK_25 = ~CLOCK_25;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_real = 0, n_ferr = 0, n_ovr = 0, n_pop = 0, n_frames = 0;
    int last_start = 0;
    logic [16:0] rxq[$];
    logic [7:0]  txq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge CLOCK_25) cyc <= cyc + 1;

    always @(negedge CLOCK_25) begin
        if (reset_reg_N) begin
            if (sys_real)    n_real++;
            if (framing_err) n_ferr++;
            if (overrun)     n_ovr++;
            if (rx_valid && rx_ready) begin
                n_pop++;
                chk("rx_unexpected_pop", 32'(rxq.size() != 0), 1);
                if (rxq.size() != 0)
                    chk("rx_entry", {15'd0, rx_data, rx_is_status, rx_byte_nr}, {15'd0, rxq.pop_front()});
            end
        end
    end

    // TX line decoder: mid-bit sampling at the nominal 64-cycle bit time.
    initial begin : tx_dec
        logic [7:0] b;
        forever begin
            @(negedge midi_txd);
            last_start = cyc;
            repeat (BIT/2) @(posedge CLOCK_25);
            #1 chk("tx_start_bit", 32'(midi_txd), 0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(posedge CLOCK_25);
                #1 b[i] = midi_txd;
            end
            repeat (BIT) @(posedge CLOCK_25);
            #1 chk("tx_stop_bit", 32'(midi_txd), 1);
            n_frames++;
            chk("tx_unexpected_frame", 32'(txq.size() != 0), 1);
            if (txq.size() != 0) chk("tx_byte", 32'(b), 32'(txq.pop_front()));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK_25);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        midi_rxd = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            midi_rxd = b[i];
            wait_clk(BIT);
        end
        midi_rxd = stop;
        wait_clk(BIT);
    endtask

    task automatic tx_push(input logic [7:0] b);
        int n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 1000) begin
            wait_clk(1);
            n++;
        end
        chk("tx_push_timeout", 32'(n < 1000), 1);
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    initial begin
        int n, d;
        logic [7:0] tx_bytes [6];
        reset_reg_N = 1'b0;
        midi_rxd    = 1'b1;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        wait_clk(5);
        chk("rst_txd", 32'(midi_txd), 1);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_tx_busy", 32'(tx_busy), 0);
        chk("rst_cur_status", 32'(cur_status), 0);
        chk("rst_sys_real_dat", 32'(sys_real_dat), 0);
        chk("rst_rx_word", {15'd0, rx_data, rx_is_status, rx_byte_nr}, 0);
        chk("rst_pulses", {29'd0, sys_real, framing_err, overrun}, 0);
        reset_reg_N = 1'b1;
        wait_clk(3);
        chk("post_rst_idle", {28'd0, midi_txd, rx_valid, tx_ready, tx_busy}, 32'b1010);

        // Plain note-on message
        rx_ready = 1'b1;
        rxq.push_back({8'h90, 1'b1, 8'd0});
        rxq.push_back({8'h3C, 1'b0, 8'd1});
        rxq.push_back({8'h64, 1'b0, 8'd2});
        send_rx(8'h90, 1); send_rx(8'h3C, 1); send_rx(8'h64, 1);
        wait_clk(2*BIT);
        chk("msg1_pops", 32'(n_pop), 3);
        chk("msg1_queue_left", 32'(rxq.size()), 0);
        chk("msg1_cur_status", 32'(cur_status), 32'h90);
        chk("msg1_errs", 32'(n_ferr + n_ovr + n_real), 0);

        // Realtime byte interleaved in a message
        rxq.push_back({8'h90, 1'b1, 8'd0});
        rxq.push_back({8'h3C, 1'b0, 8'd1});
        rxq.push_back({8'h64, 1'b0, 8'd2});
        send_rx(8'h90, 1); send_rx(8'h3C, 1); send_rx(8'hF8, 1); send_rx(8'h64, 1);
        wait_clk(2*BIT);
        chk("rt_pops", 32'(n_pop), 6);
        chk("rt_sys_real_pulses", 32'(n_real), 1);
        chk("rt_sys_real_dat", 32'(sys_real_dat), 32'hF8);
        chk("rt_queue_left", 32'(rxq.size()), 0);

        // Bad stop bit, line held low 2 ms, then a good byte
        send_rx(8'h55, 0);
        wait_clk(CLK_HZ / 500);
        midi_rxd = 1'b1;
        wait_clk(BIT);
        chk("ferr_pulses", 32'(n_ferr), 1);
        chk("ferr_no_push", 32'(n_pop), 6);
        rxq.push_back({8'h42, 1'b0, 8'd3});
        send_rx(8'h42, 1);
        wait_clk(2*BIT);
        chk("after_ferr_pops", 32'(n_pop), 7);
        chk("after_ferr_queue", 32'(rxq.size()), 0);
        chk("after_ferr_pulses", 32'(n_ferr), 1);

        // Half-bit glitch on idle line
        midi_rxd = 1'b0;
        wait_clk(8*DIV);
        midi_rxd = 1'b1;
        wait_clk(2*BIT);
        chk("glitch_no_push", 32'(n_pop), 7);
        chk("glitch_no_ferr", 32'(n_ferr), 1);
        chk("glitch_rx_valid", 32'(rx_valid), 0);

        // Overrun: nine bytes with consumer stalled
        rx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) rxq.push_back({8'(i), 1'b0, 8'(3 + i)});
        for (int i = 1; i <= 9; i++) send_rx(8'(i), 1);
        wait_clk(2*BIT);
        chk("ovr_pulses", 32'(n_ovr), 1);
        chk("ovr_rx_valid", 32'(rx_valid), 1);
        chk("ovr_no_pop_yet", 32'(n_pop), 7);
        rx_ready = 1'b1;
        n = 0;
        while (rxq.size() != 0 && n < 100) begin wait_clk(1); n++; end
        wait_clk(3);
        chk("ovr_drain_pops", 32'(n_pop), 15);
        chk("ovr_drain_empty", 32'(rx_valid), 0);
        chk("ovr_pulses_final", 32'(n_ovr), 1);

        // Transmit
        tx_bytes = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};
        for (int i = 0; i < 6; i++) begin
`ifdef MIDI_RUNNING_STATUS_TX_EN
            if (i != 3) txq.push_back(tx_bytes[i]);
`else
            txq.push_back(tx_bytes[i]);
`endif
        end
        for (int i = 0; i < 6; i++) tx_push(tx_bytes[i]);
        chk("tx_busy_active", 32'(tx_busy), 1);
        n = 0;
        while (tx_busy && n < 8*10*BIT) begin wait_clk(1); n++; end
        chk("tx_busy_timeout", 32'(n < 8*10*BIT), 1);
        d = cyc - last_start;
        chk("tx_busy_fall_after_stop", 32'(d >= 10*BIT - DIV && d <= 10*BIT + DIV), 1);
        wait_clk(BIT);
`ifdef MIDI_RUNNING_STATUS_TX_EN
        chk("tx_frames", 32'(n_frames), 5);
`else
        chk("tx_frames", 32'(n_frames), 6);
`endif
        chk("tx_queue_left", 32'(txq.size()), 0);
        chk("tx_idle_high", 32'(midi_txd), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
